// File: rtl/ntru_pkg.sv
// Shared NTRU definitions: default polynomial length, trit encoding and sampler FSM states.
package ntru_pkg;

  localparam int unsigned NTRU_N = 701;

  typedef enum logic [1:0] {
    TRIT_ZERO = 2'b00,
    TRIT_POS  = 2'b01,
    TRIT_NEG  = 2'b10
  } trit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_PAD,
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/mod3_u8.sv
// Combinational reduction of an unsigned byte mod 3 into a trit, by repeated nibble/pair folding
// (16 = 4 = 1 mod 3, so digit sums preserve the residue).
module mod3_u8
  import ntru_pkg::*;
(
  input  logic [7:0] x,
  output trit_t      r
);

  logic [4:0] s1;
  logic [3:0] s2;
  logic [2:0] s3;
  logic [1:0] s4;

  always_comb begin
    s1 = 5'(x[7:4]) + 5'(x[3:0]);      // 0..30
    s2 = 4'(s1[4]) + s1[3:0];          // 0..15
    s3 = 3'(s2[3:2]) + 3'(s2[1:0]);    // 0..6
    s4 = 2'(s3[2]) + s3[1:0];          // 0..3, where 3 is residue 0
    case (s4)
      2'd1:    r = TRIT_POS;
      2'd2:    r = TRIT_NEG;
      default: r = TRIT_ZERO;
    endcase
  end

endmodule

// File: rtl/ternary_sampler.sv
// Samples one ternary polynomial from an 8-bit coin stream; coefficient N-1 is forced to zero.
// Optional TERNARY_SAMPLER_BIAS_REJECT_EN drops byte 0xFF so the mod-3 map is exactly uniform.
module ternary_sampler
  import ntru_pkg::*;
#(
  parameter int unsigned N     = NTRU_N,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       coins,
  input  logic             coins_valid,
  output logic             coins_ready,
  output logic [1:0]       coef,
  output logic [IDX_W-1:0] coef_idx,
  output logic             coef_last,
  output logic             coef_valid,
  input  logic             coef_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_PENULT = IDX_W'(N - 2);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [1:0]       coef_d;
  logic [IDX_W-1:0] idx_d;
  logic             last_d;
  logic             valid_d;
  logic             done_d;
  logic             slot_free;
  logic             byte_drop;
  trit_t            trit;

  mod3_u8 u_mod3 (
    .x (coins),
    .r (trit)
  );

`ifdef TERNARY_SAMPLER_BIAS_REJECT_EN
  assign byte_drop = (coins == 8'hFF);
`else
  assign byte_drop = 1'b0;
`endif

  assign busy = (state_q != ST_IDLE);

  // State and output-slot registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      coef       <= 2'b00;
      coef_idx   <= '0;
      coef_last  <= 1'b0;
      coef_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      coef       <= coef_d;
      coef_idx   <= idx_d;
      coef_last  <= last_d;
      coef_valid <= valid_d;
      done       <= done_d;
    end
  end

  // Next state and slot contents; a drain and a reload may coincide for full throughput
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    coef_d      = coef;
    idx_d       = coef_idx;
    last_d      = coef_last;
    valid_d     = coef_valid;
    done_d      = 1'b0;
    coins_ready = 1'b0;
    slot_free   = !coef_valid || coef_ready;

    if (coef_valid && coef_ready) valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end
      end
      ST_SAMPLE: begin
        coins_ready = slot_free;
        if (coins_valid && slot_free && !byte_drop) begin
          coef_d  = trit;
          idx_d   = cnt_q;
          last_d  = 1'b0;
          valid_d = 1'b1;
          cnt_d   = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_PENULT) state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        if (slot_free) begin
          coef_d  = TRIT_ZERO;
          idx_d   = IDX_LAST;
          last_d  = 1'b1;
          valid_d = 1'b1;
          cnt_d   = IDX_LAST;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (coef_valid && coef_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ternary_sampler.sv
// Bench for ternary_sampler: scoreboard on a full-length instance plus a cycle-exact N=5 instance.
module tb_ternary_sampler;

  localparam int unsigned NB  = 701;
  localparam int unsigned IW  = $clog2(NB);
  localparam int unsigned NS  = 5;
  localparam int unsigned IW5 = $clog2(NS);
`ifdef TERNARY_SAMPLER_BIAS_REJECT_EN
  localparam bit REJ = 1'b1;
`else
  localparam bit REJ = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]    coef;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  typedef struct {
    logic [7:0] coins;
    logic [1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // full-length instance
  logic          start, coins_valid, coins_ready, coef_last, coef_valid, coef_ready, busy, done;
  logic [7:0]    coins;
  logic [1:0]    coef;
  logic [IW-1:0] coef_idx;

  // short instance
  logic           s_start, s_coins_valid, s_coins_ready, s_coef_last, s_coef_valid, s_busy, s_done;
  logic [7:0]     s_coins;
  logic [1:0]     s_coef;
  logic [IW5-1:0] s_coef_idx;

  ternary_sampler #(.N(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .coins(coins), .coins_valid(coins_valid),
    .coins_ready(coins_ready), .coef(coef), .coef_idx(coef_idx), .coef_last(coef_last),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .busy(busy), .done(done)
  );

  ternary_sampler #(.N(NS)) dut5 (
    .clk(clk), .rst(rst), .start(s_start), .coins(s_coins), .coins_valid(s_coins_valid),
    .coins_ready(s_coins_ready), .coef(s_coef), .coef_idx(s_coef_idx), .coef_last(s_coef_last),
    .coef_valid(s_coef_valid), .coef_ready(1'b1), .busy(s_busy), .done(s_done)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  exp_t        sbq[$];
  int unsigned m_cnt = 0;
  int unsigned done_cnt = 0;
  bit          exp_done = 1'b0;
  logic [1:0]  drv_exp = 2'b00;
  vec_t        tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] trit_of(input logic [7:0] b);
    int r;
    r = int'(b) % 3;
    return (r == 1) ? 2'b01 : (r == 2) ? 2'b10 : 2'b00;
  endfunction

  // Scoreboard: pop on output handshake first, then push for the byte consumed in the same cycle
  always @(negedge clk) begin
    if (rst) begin
      exp_t e;
      if (exp_done || done) begin
        check("done_pulse", 32'(done), 32'(exp_done));
        if (exp_done) check("busy_at_done", 32'(busy), 0);
        if (done) done_cnt++;
      end
      exp_done = 1'b0;
      if (coef_valid && coef_ready) begin
        if (sbq.size() == 0) begin
          check("sb_nonempty", 32'(sbq.size()), 1);
        end else begin
          e = sbq.pop_front();
          check("coef", 32'(coef), 32'(e.coef));
          check("coef_idx", 32'(coef_idx), 32'(e.idx));
          check("coef_last", 32'(coef_last), 32'(e.last));
          if (e.last) exp_done = 1'b1;
        end
      end
      if (coins_valid && coins_ready && !(REJ && coins == 8'hFF)) begin
        sbq.push_back('{coef: drv_exp, idx: IW'(m_cnt), last: 1'b0});
        m_cnt++;
        if (m_cnt == NB - 1) sbq.push_back('{coef: 2'b00, idx: IW'(NB - 1), last: 1'b1});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic [1:0] e);
    bit ok;
    coins       = b;
    drv_exp     = e;
    coins_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (coins_ready) ok = 1'b1;
    end
    check("coins_accept", 32'(ok), 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_coins_ready"}, 32'(coins_ready), 0);
    check({tag, "_coef"}, 32'(coef), 0);
    check({tag, "_coef_idx"}, 32'(coef_idx), 0);
    check({tag, "_coef_last"}, 32'(coef_last), 0);
    check({tag, "_coef_valid"}, 32'(coef_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    logic [7:0] b5[4];
    logic [1:0] c5[4];
    logic [7:0] b;
    exp_t       f;

    tbl = '{'{8'h07, 2'b01}, '{8'h05, 2'b10}, '{8'h03, 2'b00}, '{8'h00, 2'b00},
            '{8'h01, 2'b01}, '{8'h02, 2'b10}, '{8'h80, 2'b10}, '{8'hFE, 2'b10},
            '{8'h10, 2'b01}, '{8'h1E, 2'b00}, '{8'hAA, 2'b10}, '{8'h55, 2'b01},
            '{8'h64, 2'b01}, '{8'hC8, 2'b10}, '{8'h0F, 2'b00}, '{8'hF0, 2'b00}};
    b5 = '{8'd1, 8'd2, 8'd4, 8'd8};
    c5 = '{2'b01, 2'b10, 2'b01, 2'b10};

    rst = 1'b0;
    start = 1'b0; coins = 8'h00; coins_valid = 1'b0; coef_ready = 1'b1;
    s_start = 1'b0; s_coins = 8'h00; s_coins_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    check("rst0_s_busy", 32'(s_busy), 0);
    check("rst0_s_valid", 32'(s_coef_valid), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // N=5: bytes 1,2,4,8 then zero pad, done 6 cycles after start
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0; s_coins_valid = 1'b1; s_coins = b5[0];
    check("n5_busy", 32'(s_busy), 1);
    check("n5_coins_ready", 32'(s_coins_ready), 1);
    check("n5_valid0", 32'(s_coef_valid), 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k < 3) s_coins = b5[k+1];
      else s_coins_valid = 1'b0;
      check("n5_coef", 32'(s_coef), 32'(c5[k]));
      check("n5_idx", 32'(s_coef_idx), 32'(k));
      check("n5_valid", 32'(s_coef_valid), 1);
      check("n5_last", 32'(s_coef_last), 0);
    end
    check("n5_pad_coins_ready", 32'(s_coins_ready), 0);
    @(posedge clk); #1;
    check("n5_pad_coef", 32'(s_coef), 0);
    check("n5_pad_idx", 32'(s_coef_idx), 4);
    check("n5_pad_last", 32'(s_coef_last), 1);
    check("n5_pad_done", 32'(s_done), 0);
    @(posedge clk); #1;
    check("n5_done", 32'(s_done), 1);
    check("n5_busy_done", 32'(s_busy), 0);
    check("n5_valid_done", 32'(s_coef_valid), 0);
    @(posedge clk); #1;
    check("n5_done_pulse", 32'(s_done), 0);

    // Polynomial aborted by reset at cnt = 37
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("p1_busy", 32'(busy), 1);
    check("p1_coins_ready", 32'(coins_ready), 1);
    for (int i = 0; i < 37; i++) begin
      if (i < 16) send_byte(tbl[i].coins, tbl[i].exp);
      else begin
        b = 8'($urandom_range(0, 254));
        send_byte(b, trit_of(b));
      end
    end
    coins_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    check("abort_no_done", 32'(done_cnt), 0);
    sbq.delete();
    m_cnt = 0;
    exp_done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Full polynomial: 0xFF at idx 2, stray start, stall, valid gaps
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'h07, 2'b01);
    send_byte(8'h05, 2'b10);
    send_byte(8'hFF, 2'b00);
    send_byte(8'h03, 2'b00);
    for (int i = 0; m_cnt < NB - 1 && i < 3000; i++) begin
      if (i[0]) begin
        coins_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (i == 100) start = 1'b1;
      if (i == 50) begin
        coef_ready = 1'b0;
        b = 8'($urandom_range(0, 255));
        coins = b; drv_exp = trit_of(b); coins_valid = 1'b1;
        f = sbq[0];
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("stall_coins_ready", 32'(coins_ready), 0);
          check("stall_valid", 32'(coef_valid), 1);
          check("stall_coef", 32'(coef), 32'(f.coef));
          check("stall_idx", 32'(coef_idx), 32'(f.idx));
        end
        @(posedge clk); #1;
        coef_ready = 1'b1;
        send_byte(b, trit_of(b));
      end else begin
        b = 8'($urandom_range(0, 255));
        send_byte(b, trit_of(b));
      end
      start = 1'b0;
    end
    coins_valid = 1'b0;
    for (int t = 0; t < 30 && done_cnt == 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("done_count", 32'(done_cnt), 1);
    check("sb_drained", 32'(sbq.size()), 0);
    check("final_busy", 32'(busy), 0);
    check("final_valid", 32'(coef_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ternary_sampler.md
# ternary_sampler

Samples one ternary polynomial, NTRU-HRSS `sample_iid` style, from the 8-bit coin stream of the LFSR random source. Each accepted byte is reduced mod 3 into one trit for coefficients 0..N-2. Coefficient N-1 is forced to 0. Sits directly downstream of the coin generator and feeds trits in index order to the polynomial store / key-generation datapath over a valid/ready handshake.

## Interface
- `N`, default 701: polynomial length; N-1 coefficients are sampled.
- `IDX_W`, default `$clog2(N)`: width of the coefficient index.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low; all state cleared while low.
- `start`  in  1  begin one polynomial; honoured only in IDLE.
- `coins`  in  8  random byte from the LFSR.
- `coins_valid`  in  1  `coins` valid this cycle.
- `coins_ready`  out  1  byte consumed when `coins_valid && coins_ready`.
- `coef`  out  2  trit: 2'b00 = 0, 2'b01 = +1, 2'b10 = -1; 2'b11 is never driven.
- `coef_idx`  out  IDX_W  index of `coef`.
- `coef_last`  out  1  marks index N-1.
- `coef_valid`  out  1  output slot full.
- `coef_ready`  in  1  consumer accepts when `coef_valid && coef_ready`.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse after index N-1 is accepted.

## Operation
- FSM states: IDLE, SAMPLE, PAD, FLUSH.
- IDLE -> SAMPLE on `start`. Clears the produced-count `cnt`. `start` in any other state is ignored.
- SAMPLE:
  - `coins_ready = !coef_valid || coef_ready`.
  - On byte accept: r = coins mod 3. The slot loads `coef` = {0 -> 00, 1 -> 01, 2 -> 10}, `coef_idx = cnt`, `coef_valid = 1`, then `cnt++`.
  - When the byte for index N-2 is accepted, go to PAD.
- PAD:
  - `coins_ready = 0`.
  - When the slot is free or draining, load `coef = 00`, `coef_idx = N-1`, `coef_last = 1`, then go to FLUSH.
- FLUSH: when the last trit is accepted, clear `coef_valid`, pulse `done`, return to IDLE.
- Output slot is a single register:
  - Contents hold stable while `coef_valid && !coef_ready`.
  - A simultaneous accept and reload in the same cycle is permitted, giving full throughput.
- Mod-3 arithmetic is on the unsigned 8-bit byte, so r is in {0,1,2}. `cnt` never exceeds N-1 and never wraps.
- `coins_valid` low stalls sampling without losing state. Bytes offered while `coins_ready` is low are not consumed; the LFSR is free-running, so they are dropped upstream.
- Async reset mid-polynomial aborts it: state returns to IDLE and no `done` is issued.

## Timing
- Reset values: `coins_ready = 0`, `coef = 0`, `coef_idx = 0`, `coef_last = 0`, `coef_valid = 0`, `busy = 0`, `done = 0`.
- `start` at cycle t: `busy` = 1 and `coins_ready` = 1 at t+1.
- Byte accepted at cycle t: `coef_valid` = 1 at t+1. Latency is 1 cycle.
- With `coins_valid` and `coef_ready` held high, one trit per cycle. A full polynomial is N trits plus 1 cycle of start overhead.
- `done` is high in the cycle after the index N-1 handshake; `busy` is low in that same cycle.
- `coef_last` is high only together with `coef_idx = N-1`.

## Configuration
- `TERNARY_SAMPLER_BIAS_REJECT_EN` defined:
  - Byte 0xFF is consumed but produces no trit, and `cnt` does not advance.
  - The remaining 255 values give an exactly uniform mod 3.
- Macro undefined: 0xFF maps to 0, which is the HRSS reference behaviour and slightly biased toward 0.

## Structure
- Shared package `ntru_pkg`:
  - `N` default constant.
  - `trit_t` enum (`TRIT_ZERO`, `TRIT_POS`, `TRIT_NEG`).
  - FSM state typedef.
- Sub-module `mod3_u8`: combinational 8-bit to {0,1,2} reduction returning `trit_t`, implemented by nibble folding and reused by later samplers.

## Test plan
- Reset low mid-SAMPLE at `cnt = 37` -> all outputs at reset values immediately. After release, the next `start` restarts at `coef_idx = 0`.
- `start`, `coins = 0x07`, `coef_ready = 1` -> next cycle `coef = 01`, `coef_idx = 0`. Then `0x05` gives `coef = 10` at `coef_idx = 1`; `0x03` gives `00` at `coef_idx = 2`.
- `coef_ready` held low for 5 cycles with `coef_valid` high -> `coef`/`coef_idx` stable and `coins_ready = 0`. On release, one trit per cycle with no byte lost or duplicated.
- `N = 5`, bytes 1,2,4,8 -> trits 01,10,01,10 at idx 0..3. Then idx 4 = 00 with `coef_last = 1`, `done` pulse, `busy` low; total 6 cycles after `start`.
- Byte 0xFF at idx 2 -> without macro, trit 00 at idx 2. With `TERNARY_SAMPLER_BIAS_REJECT_EN`, no output that cycle and the next byte takes idx 2.
- `start` pulsed during SAMPLE and `coins_valid` toggled every other cycle -> `start` ignored, output indices contiguous, `done` exactly once.
